// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader; the CPU's reset PC
// also uses DEFAULT_BASE_ADDR so fetch starts where the loader writes.
package imem_loader_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_HI = 3'd1;
  localparam logic [2:0] LEN_LO = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] CSUM   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

  // States in which the loader is willing to take a stream byte.
  function automatic logic accepts_bytes(input logic [2:0] st);
    return (st == LEN_HI) || (st == LEN_LO) || (st == DATA) || (st == CSUM);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Collects four stream bytes MSB-first into one big-endian 32-bit word.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word_out
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (byte_valid) begin
      shift_d = {shift_q[15:0], byte_in};
      idx_d   = idx_q + 2'd1;
    end
  end

  // The fourth byte completes the word combinationally so the loader can
  // register the write on the same edge that accepts that byte.
  assign word_valid = byte_valid && !clear && (idx_q == 2'd3);
  assign word_out   = {shift_q, byte_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a length/data/checksum byte stream and holds
// the CPU in reset until a complete, checksum-verified program is present.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_loaded
);

  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

  logic [2:0]       state_q, state_d;
  logic [7:0]       n_hi_q, n_hi_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [7:0]       csum_q, csum_d;
  logic             in_ready_q, in_ready_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             xfer;
  logic             start_ok;
  logic             data_byte;
  logic [15:0]      len_full;
  logic             word_valid;
  logic [31:0]      word;

  assign xfer      = in_valid && in_ready_q;
  assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign data_byte = xfer && (state_q == DATA);
  assign len_full  = {n_hi_q, in_data};

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_valid (data_byte),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word_out   (word)
  );

  always_comb begin
    state_d   = state_q;
    n_hi_d    = n_hi_q;
    n_d       = n_q;
    words_d   = words_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    err_d     = err_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_ok) begin
          state_d = LEN_HI;
          words_d = '0;
          csum_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          n_hi_d  = in_data;
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          n_d = CNT_W'(len_full);
          if ({1'b0, len_full} > DEPTH_LIM) begin
            state_d = ERR;
          end else if (len_full == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ in_data;
        end
        // Address uses the pre-increment count so word k lands at BASE+4k.
        if (word_valid) begin
          wr_en_d   = 1'b1;
          wr_data_d = word;
          wr_addr_d = BASE_ADDR + (32'(words_q) << 2);
          words_d   = words_q + CNT_W'(1);
          if ((words_q + CNT_W'(1)) == n_q) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          state_d = (in_data == csum_q) ? DONE : ERR;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status flags follow the terminal state by one cycle, and a restart
    // clears them on the same edge that leaves DONE/ERR.
    if ((state_q == DONE) && !start_ok) begin
      done_d = 1'b1;
    end
    if ((state_q == ERR) && !start_ok) begin
      err_d = 1'b1;
    end
    cpu_hold_d = !((state_q == DONE) && !start_ok);
    in_ready_d = accepts_bytes(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      n_hi_q     <= '0;
      n_q        <= '0;
      words_q    <= '0;
      csum_q     <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= BASE_ADDR;
      wr_data_q  <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_hi_q     <= n_hi_d;
      n_q        <= n_d;
      words_q    <= words_d;
      csum_q     <= csum_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal, bad-checksum, oversize, zero-length,
// throttled/back-to-back and mid-load reset scenarios.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] addr_log[$];
  logic [31:0] data_log[$];
  logic [7:0]  stream[$];

  imem_loader #(
    .DEPTH_WORDS (4),
    .BASE_ADDR   (32'h0000_0000),
    .CNT_W       (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Record every memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      addr_log.push_back(wr_addr);
      data_log.push_back(wr_data);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int waits;
    waits    = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input int throttle_bytes);
    for (int i = 0; i < stream.size(); i++) begin
      if (i < throttle_bytes) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      send_byte(stream[i]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({in_ready, wr_en, cpu_hold, done, err} !== 5'b00100) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: in_ready,wr_en,cpu_hold,done,err=%b required 00100",
               {in_ready, wr_en, cpu_hold, done, err});
    end
    tests_run++;
    if (wr_addr !== 32'h0 || wr_data !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_wr_bus: addr=%h data=%h required 0/0", wr_addr, wr_data);
    end
    tests_run++;
    if (words_loaded !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_words: got %0d required 0", words_loaded);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_a[2] = '{32'h0, 32'h4};
    logic [31:0] exp_d[2] = '{32'h2008_0005, 32'h0109_5020};
    addr_log.delete(); data_log.delete();
    pulse_start();
    // XOR of 20 08 00 05 01 09 50 20 is 0x55.
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h55};
    send_stream(0);
    tests_run++;
    if (done !== 1'b0 || cpu_hold !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL basic_latency: done=%b cpu_hold=%b required 0/1 one cycle after csum", done, cpu_hold);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_done: done=%b cpu_hold=%b err=%b required 1/0/0", done, cpu_hold, err);
    end
    tests_run++;
    if (words_loaded !== 16'd2 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_words: words=%0d in_ready=%b required 2/0", words_loaded, in_ready);
    end
    tests_run++;
    if (addr_log.size() != 2) begin
      tests_failed++;
      $display("[TB] FAIL basic_write_count: got %0d required 2", addr_log.size());
    end
    for (int i = 0; i < 2; i++) begin
      if (i < addr_log.size()) begin
        tests_run++;
        if (addr_log[i] !== exp_a[i] || data_log[i] !== exp_d[i]) begin
          tests_failed++;
          $display("[TB] FAIL basic_write%0d: got %h/%h required %h/%h",
                   i, addr_log[i], data_log[i], exp_a[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_bad_csum();
    addr_log.delete(); data_log.delete();
    pulse_start();
    tests_run++;
    if (done !== 1'b0 || cpu_hold !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL restart_clears_done: done=%b cpu_hold=%b required 0/1", done, cpu_hold);
    end
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h45};
    send_stream(0);
    @(negedge clk);
    tests_run++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL badcsum_flags: err=%b done=%b cpu_hold=%b required 1/0/1", err, done, cpu_hold);
    end
    tests_run++;
    if (addr_log.size() != 2 || words_loaded !== 16'd2) begin
      tests_failed++;
      $display("[TB] FAIL badcsum_writes: writes=%0d words=%0d required 2/2", addr_log.size(), words_loaded);
    end
  endtask

  task automatic test_oversize();
    addr_log.delete(); data_log.delete();
    pulse_start();
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL retry_clears_err: err=%b required 0", err);
    end
    send_byte(8'h00);
    send_byte(8'h05);
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL oversize_ready: in_ready=%b required 0", in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (err !== 1'b1 || cpu_hold !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL oversize_err: err=%b cpu_hold=%b required 1/1", err, cpu_hold);
    end
    in_data = 8'hAB; in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (addr_log.size() != 0 || words_loaded !== 16'd0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL oversize_no_write: writes=%0d words=%0d in_ready=%b required 0/0/0",
               addr_log.size(), words_loaded, in_ready);
    end
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    @(negedge clk);
    tests_run++;
    if (err !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL oversize_hibyte: err=%b in_ready=%b required 1/0", err, in_ready);
    end
  endtask

  task automatic test_zero_len();
    addr_log.delete(); data_log.delete();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL zero_csum_ready: in_ready=%b required 1", in_ready);
    end
    send_byte(8'h00);
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || err !== 1'b0 || words_loaded !== 16'd0 || addr_log.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL zero_ok: done=%b err=%b words=%0d writes=%0d required 1/0/0/0",
               done, err, words_loaded, addr_log.size());
    end
    pulse_start();
    stream = '{8'h00, 8'h00, 8'h01};
    send_stream(0);
    @(negedge clk);
    tests_run++;
    if (err !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL zero_badcsum: err=%b done=%b required 1/0", err, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d[4] = '{32'h1122_3344, 32'hAABB_CCDD, 32'h0102_0304, 32'hDEAD_BEEF};
    addr_log.delete(); data_log.delete();
    pulse_start();
    // Header and first word throttled, last three words streamed without gaps.
    // XOR of all 16 data bytes is 0x62.
    stream = '{8'h00, 8'h04,
               8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
               8'h01, 8'h02, 8'h03, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h62};
    send_stream(6);
    repeat (2) @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || words_loaded !== 16'd4) begin
      tests_failed++;
      $display("[TB] FAIL b2b_done: done=%b words=%0d required 1/4", done, words_loaded);
    end
    tests_run++;
    if (addr_log.size() != 4) begin
      tests_failed++;
      $display("[TB] FAIL b2b_write_count: got %0d required 4", addr_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < addr_log.size()) begin
        tests_run++;
        if (addr_log[i] !== 32'(4 * i) || data_log[i] !== exp_d[i]) begin
          tests_failed++;
          $display("[TB] FAIL b2b_write%0d: got %h/%h required %h/%h",
                   i, addr_log[i], data_log[i], 32'(4 * i), exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
    send_stream(0);
    tests_run++;
    if (wr_en !== 1'b1 || wr_data !== 32'h2008_0005) begin
      tests_failed++;
      $display("[TB] FAIL midload_first_write: wr_en=%b data=%h required 1/20080005", wr_en, wr_data);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({in_ready, wr_en, cpu_hold, done, err} !== 5'b00100 || wr_addr !== 32'h0 ||
        wr_data !== 32'h0 || words_loaded !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: flags=%b addr=%h data=%h words=%0d required 00100/0/0/0",
               {in_ready, wr_en, cpu_hold, done, err}, wr_addr, wr_data, words_loaded);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    addr_log.delete(); data_log.delete();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    pulse_start();
    stream = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h55};
    send_stream(0);
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || words_loaded !== 16'd2) begin
      tests_failed++;
      $display("[TB] FAIL reload_done: done=%b cpu_hold=%b words=%0d required 1/0/2",
               done, cpu_hold, words_loaded);
    end
    tests_run++;
    if (addr_log.size() != 2) begin
      tests_failed++;
      $display("[TB] FAIL reload_write_count: got %0d required 2", addr_log.size());
    end else begin
      tests_run++;
      if (addr_log[0] !== 32'h0 || data_log[0] !== 32'h2008_0005 ||
          addr_log[1] !== 32'h4 || data_log[1] !== 32'h0109_5020) begin
        tests_failed++;
        $display("[TB] FAIL reload_writes: got %h/%h %h/%h required 0/20080005 4/01095020",
                 addr_log[0], data_log[0], addr_log[1], data_log[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_oversize();
    test_zero_len();
    test_back_to_back();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
